registered_full_adder: RTL and testbench
========================================

Name: registered_full_adder

Overview:
- Parameterisable ripple-carry adder built from 1-bit full-adder cells: computes {carry, sum} = A + B + cin.
- Default configuration (WIDTH=1, REG_OUT=0) is a pure combinational single-bit full adder.
- An optional output register stage with valid tracking lets it sit inside pipelined datapaths.
- It is a leaf arithmetic block used wherever a small add with carry-in/carry-out is needed.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).
- REG_OUT, 0, 0 = combinational outputs; 1 = outputs registered with one cycle of latency.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies A/B/cin. Used only when REG_OUT=1.
- A  input  WIDTH  addend A, unsigned/two's-complement agnostic.
- B  input  WIDTH  addend B.
- cin  input  1  carry in.
- sum  output  WIDTH  low WIDTH bits of A+B+cin.
- carry  output  1  carry out of the MSB (bit WIDTH of the full result).
- ovf  output  1  signed overflow, equal to the carry into the MSB XOR the carry out of the MSB.
- out_valid  output  1  sum/carry/ovf are valid.

Behaviour:
- Cell equations, per bit i with c[0]=cin:
  - s[i] = A[i]^B[i]^c[i]
  - c[i+1] = (A[i]&B[i]) | (A[i]&c[i]) | (B[i]&c[i])
  - carry = c[WIDTH]
  - ovf = c[WIDTH]^c[WIDTH-1]
  - For WIDTH=1, c[WIDTH-1] is cin.
- Arithmetic is modulo 2^WIDTH. Full result {carry,sum} is exactly A+B+cin (max 2^(WIDTH+1)-1).
- REG_OUT=0:
  - sum/carry/ovf are purely combinational from A/B/cin with zero latency.
  - out_valid = in_valid, combinational.
  - clk and rst_n do not affect sum/carry/ovf.
  - No X/latch permitted: every input combination yields a defined output.
- REG_OUT=1:
  - On each rising clk edge with in_valid=1, register sum/carry/ovf from the current inputs and set out_valid=1.
  - On a rising edge with in_valid=0, sum/carry/ovf hold their previous values and out_valid=0.
  - Latency is exactly 1 cycle; throughput is 1 result per cycle; no backpressure.
- Reset:
  - rst_n low immediately (asynchronously) forces sum=0, carry=0, ovf=0, out_valid=0 in the registered build.
  - Release is sampled at the next rising edge. The first capture occurs on the first edge after rst_n is high.
  - Reset mid-stream discards the in-flight result; no output pulse is generated for it.
- Input changes between edges do not disturb registered outputs.

Test Plan:
- WIDTH=1, REG_OUT=0: apply all 8 (A,B,cin) combinations 000..111, 10 ns apart. Required (sum,carry) pairs are 00,10,10,01,10,01,01,11.
- WIDTH=8, REG_OUT=0, wrap-around: A=0xFF, B=0x01, cin=0 -> sum=0x00, carry=1, ovf=0. A=0xFF, B=0xFF, cin=1 -> sum=0xFF, carry=1.
- WIDTH=8 signed overflow: A=0x7F, B=0x01, cin=0 -> sum=0x80, carry=0, ovf=1. A=0x80, B=0x80, cin=0 -> sum=0x00, carry=1, ovf=1.
- WIDTH=8, REG_OUT=1, latency: drive A=0x12, B=0x34, cin=1, in_valid=1 for one cycle. Next edge -> sum=0x47, carry=0, out_valid=1. Following cycle with in_valid=0 -> out_valid=0, sum holds 0x47.
- REG_OUT=1, async reset: assert rst_n=0 mid-cycle while sum=0x47. Outputs go to 0 and out_valid to 0 before the next edge. Inputs applied during reset produce no valid output.
- Random regression, WIDTH=16, both REG_OUT values, ≥10k vectors: {carry,sum} == A+B+cin and ovf matches the signed-overflow reference each valid cycle.

Source files
------------

// File: rtl/registered_full_adder.sv
// +----------------------------------------------------------------------------+
// | registered_full_adder                                                      |
// | Ripple-carry adder of 1-bit full-adder cells, optional output register.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module registered_full_adder #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf,
  output logic             out_valid
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;

  assign w_c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign w_sum[i]  = A[i] ^ B[i] ^ w_c[i];
    assign w_c[i+1]  = (A[i] & B[i]) | (A[i] & w_c[i]) | (B[i] & w_c[i]);
  end

  // Carry into the MSB vs carry out of it; for WIDTH=1 the carry in is cin.
  assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_ovf;
    logic             r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sum   <= '0;
        r_carry <= 1'b0;
        r_ovf   <= 1'b0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= in_valid;
        // Result fields hold across idle cycles; only out_valid drops.
        if (in_valid) begin
          r_sum   <= w_sum;
          r_carry <= w_c[WIDTH];
          r_ovf   <= w_ovf;
        end
      end
    end

    assign sum       = r_sum;
    assign carry     = r_carry;
    assign ovf       = r_ovf;
    assign out_valid = r_valid;
  end else begin : g_comb
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst_n;

    assign sum       = w_sum;
    assign carry     = w_c[WIDTH];
    assign ovf       = w_ovf;
    assign out_valid = in_valid;
  end

endmodule

`default_nettype wire

// File: tb/tb_registered_full_adder.sv
// +----------------------------------------------------------------------------+
// | tb_registered_full_adder                                                   |
// | Self-checking bench: directed cases plus randomized WIDTH=16 regression.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_registered_full_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // WIDTH=1 combinational
  logic       a1, b1, ci1, iv1, s1, c1, o1, v1;
  // WIDTH=8 combinational and registered share inputs
  logic [7:0] a8, b8, s8c, s8r;
  logic       ci8, iv8, c8c, o8c, v8c, c8r, o8r, v8r;
  // WIDTH=16 combinational and registered share inputs
  logic [15:0] a16, b16, s16c, s16r;
  logic        ci16, iv16, c16c, o16c, v16c, c16r, o16r, v16r;

  registered_full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .A(a1), .B(b1), .cin(ci1),
    .sum(s1), .carry(c1), .ovf(o1), .out_valid(v1));

  registered_full_adder #(.WIDTH(8), .REG_OUT(1'b0)) u_d8c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .A(a8), .B(b8), .cin(ci8),
    .sum(s8c), .carry(c8c), .ovf(o8c), .out_valid(v8c));

  registered_full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_d8r (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .A(a8), .B(b8), .cin(ci8),
    .sum(s8r), .carry(c8r), .ovf(o8r), .out_valid(v8r));

  registered_full_adder #(.WIDTH(16), .REG_OUT(1'b0)) u_d16c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .A(a16), .B(b16), .cin(ci16),
    .sum(s16c), .carry(c16c), .ovf(o16c), .out_valid(v16c));

  registered_full_adder #(.WIDTH(16), .REG_OUT(1'b1)) u_d16r (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .A(a16), .B(b16), .cin(ci16),
    .sum(s16r), .carry(c16r), .ovf(o16r), .out_valid(v16r));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer addition, and signed overflow as range violation.
  function automatic void model(input int w, input longint a, input longint b, input bit ci,
                                output longint s, output bit c, output bit o);
    longint full, sa, sb, sr, lim;
    full = a + b + longint'(ci);
    s    = full & ((longint'(1) << w) - 1);
    c    = ((full >> w) & 1) != 0;
    sa   = (a >= (longint'(1) << (w - 1))) ? a - (longint'(1) << w) : a;
    sb   = (b >= (longint'(1) << (w - 1))) ? b - (longint'(1) << w) : b;
    sr   = sa + sb + longint'(ci);
    lim  = longint'(1) << (w - 1);
    o    = (sr > lim - 1) || (sr < -lim);
  endfunction

  longint es, rs;
  bit     ec, eo, rc, ro, rv;
  logic [1:0] tbl [8];

  task automatic check8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci);
    @(negedge clk);
    a8 = a; b8 = b; ci8 = ci; iv8 = 1'b0;
    #1;
    model(8, longint'(a), longint'(b), ci, es, ec, eo);
    check({tag, " sum"},   s8c, es);
    check({tag, " carry"}, c8c, ec);
    check({tag, " ovf"},   o8c, eo);
  endtask

  initial begin
    tbl = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    rst_n = 1'b0;
    a1 = 0; b1 = 0; ci1 = 0; iv1 = 1'b1;
    a8 = 8'h55; b8 = 8'h66; ci8 = 1'b1; iv8 = 1'b1;
    a16 = 0; b16 = 0; ci16 = 0; iv16 = 1'b0;

    // Reset state, with valid inputs present during reset
    @(posedge clk); #1;
    check("rst sum8",    s8r, 0);
    check("rst valid8",  v8r, 0);
    check("rst sum16",   s16r, 0);
    check("rst valid16", v16r, 0);
    iv8 = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // WIDTH=1 exhaustive truth table
    for (int k = 0; k < 8; k++) begin
      logic [2:0] v;
      v = 3'(k);
      {a1, b1, ci1} = v;
      #10;
      check($sformatf("fa1 %0d sum,carry", k), {s1, c1}, tbl[k]);
      model(1, longint'(a1), longint'(b1), ci1, es, ec, eo);
      check($sformatf("fa1 %0d ovf", k), o1, eo);
      check($sformatf("fa1 %0d valid", k), v1, iv1);
    end

    // WIDTH=8 wrap-around and signed overflow boundaries
    check8("ff+01", 8'hFF, 8'h01, 1'b0);
    check("ff+01 const", {o8c, c8c, s8c}, {1'b0, 1'b1, 8'h00});
    check8("ff+ff+1", 8'hFF, 8'hFF, 1'b1);
    check("ff+ff+1 const", {c8c, s8c}, {1'b1, 8'hFF});
    check8("7f+01", 8'h7F, 8'h01, 1'b0);
    check("7f+01 const", {o8c, c8c, s8c}, {1'b1, 1'b0, 8'h80});
    check8("80+80", 8'h80, 8'h80, 1'b0);
    check("80+80 const", {o8c, c8c, s8c}, {1'b1, 1'b1, 8'h00});

    // WIDTH=8 registered latency and hold
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; ci8 = 1'b1; iv8 = 1'b1;
    #1 check("comb valid8", v8c, 1);
    check("pre-edge valid8r", v8r, 0);
    @(posedge clk); #1;
    check("lat sum8r",   s8r, 8'h47);
    check("lat carry8r", c8r, 0);
    check("lat valid8r", v8r, 1);
    iv8 = 1'b0; a8 = 8'hAA; b8 = 8'hBB;
    @(posedge clk); #1;
    check("hold sum8r",   s8r, 8'h47);
    check("hold valid8r", v8r, 0);

    // Async reset mid-cycle, inputs valid during reset
    #2 rst_n = 1'b0;
    #1;
    check("async sum8r",   s8r, 0);
    check("async valid8r", v8r, 0);
    a8 = 8'h01; b8 = 8'h02; ci8 = 1'b0; iv8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("in-rst sum8r",   s8r, 0);
    check("in-rst valid8r", v8r, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-rst sum8r",   s8r, 8'h03);
    check("post-rst valid8r", v8r, 1);
    iv8 = 1'b0;

    // WIDTH=16 random regression, both builds
    rs = 0; rc = 0; ro = 0; rv = 0;
    check("r16 init sum",   s16r, 0);
    check("r16 init valid", v16r, 0);
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      a16  = 16'($urandom);
      b16  = 16'($urandom);
      ci16 = 1'($urandom);
      iv16 = ($urandom_range(0, 3) != 0);
      if (n % 50 == 0) begin a16 = 16'hFFFF; b16 = 16'(n); end
      #1;
      model(16, longint'(a16), longint'(b16), ci16, es, ec, eo);
      check("c16 sum",   s16c, es);
      check("c16 carry", c16c, ec);
      check("c16 ovf",   o16c, eo);
      check("c16 valid", v16c, iv16);
      if (iv16) begin rs = es; rc = ec; ro = eo; end
      rv = iv16;
      @(posedge clk); #1;
      check("r16 valid", v16r, rv);
      check("r16 sum",   s16r, rs);
      check("r16 carry", c16r, rc);
      check("r16 ovf",   o16r, ro);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
